// File: rtl/dispatch_queue.sv
// Issue-stage FIFO: buffers decoded instructions, resolves operands, issues one per cycle.
// Optional statistics counters are built when DISPATCH_STATS_EN is defined.
module dispatch_queue #(
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  parameter int ROB_W   = 4,
  parameter int OPT_W   = 6,
  parameter int CDB_NUM = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [OPT_W-1:0]         in_optype,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic                     in_is_ls,
  input  logic                     in_is_jump,
  input  logic                     in_pred_jump,
  input  logic                     rob_full,
  input  logic [ROB_W-1:0]         rob_next_id,
  input  logic                     rs_full,
  input  logic                     lsb_full,
  output logic [4:0]               rs1_2reg,
  output logic [4:0]               rs2_2reg,
  input  logic [ROB_W-1:0]         reg_qi,
  input  logic [ROB_W-1:0]         reg_qj,
  input  logic [XLEN-1:0]          reg_vi,
  input  logic [XLEN-1:0]          reg_vj,
  output logic [ROB_W-1:0]         rob_qi,
  output logic [ROB_W-1:0]         rob_qj,
  input  logic                     rob_qi_rdy,
  input  logic                     rob_qj_rdy,
  input  logic [XLEN-1:0]          rob_vi,
  input  logic [XLEN-1:0]          rob_vj,
  input  logic [CDB_NUM-1:0]       cdb_valid,
  input  logic [CDB_NUM*ROB_W-1:0] cdb_alias,
  input  logic [CDB_NUM*XLEN-1:0]  cdb_value,
  output logic                     rename_en,
  output logic [4:0]               rename_rd,
  output logic [ROB_W-1:0]         rename_alias,
  output logic                     rob_en,
  output logic [XLEN-1:0]          rob_pc,
  output logic [4:0]               rob_rd,
  output logic                     rob_is_jump,
  output logic                     rob_pred_jump,
  output logic [OPT_W-1:0]         rob_optype,
  output logic                     rs_en,
  output logic                     lsb_en,
  output logic [ROB_W-1:0]         iss_alias,
  output logic [OPT_W-1:0]         iss_optype,
  output logic [XLEN-1:0]          iss_pc,
  output logic [XLEN-1:0]          iss_imm,
  output logic [XLEN-1:0]          iss_vi,
  output logic [XLEN-1:0]          iss_vj,
  output logic [ROB_W-1:0]         iss_qi,
  output logic [ROB_W-1:0]         iss_qj,
  output logic [31:0]              stat_issued,
  output logic [31:0]              stat_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0]  pc_m  [DEPTH];
  logic [XLEN-1:0]  imm_m [DEPTH];
  logic [OPT_W-1:0] opt_m [DEPTH];
  logic [4:0]       rd_m  [DEPTH];
  logic [4:0]       rs1_m [DEPTH];
  logic [4:0]       rs2_m [DEPTH];
  logic             ls_m  [DEPTH];
  logic             jmp_m [DEPTH];
  logic             pj_m  [DEPTH];

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          push, go, empty;
  logic          head_ls;
  logic [ROB_W+XLEN-1:0] op_i, op_j;

  assign empty    = (count == '0);
  assign in_ready = rdy && (count < CW'(DEPTH)) && !rollback;
  assign push     = in_valid && in_ready;
  assign head_ls  = ls_m[head];
  assign go       = rdy && !rollback && !empty && !rob_full &&
                    (head_ls ? !lsb_full : !rs_full);

  assign rs1_2reg = rs1_m[head];
  assign rs2_2reg = rs2_m[head];
  assign rob_qi   = reg_qi;
  assign rob_qj   = reg_qj;

  // Register file, then ROB, then the lowest-numbered matching CDB channel.
  function automatic logic [ROB_W+XLEN-1:0] resolve(
    input logic [ROB_W-1:0] tag,
    input logic             rrdy,
    input logic [XLEN-1:0]  rval,
    input logic [XLEN-1:0]  gval
  );
    logic [ROB_W-1:0] q;
    logic [XLEN-1:0]  v;
    logic             hit;
    hit = 1'b0;
    if (tag == '0) begin
      q = '0;
      v = gval;
    end else if (rrdy) begin
      q = '0;
      v = rval;
    end else begin
      q = tag;
      v = '0;
    end
    for (int k = 0; k < CDB_NUM; k++) begin
      if (!hit && q != '0 && cdb_valid[k] &&
          cdb_alias[k*ROB_W +: ROB_W] == q) begin
        hit = 1'b1;
        v   = cdb_value[k*XLEN +: XLEN];
      end
    end
    if (hit) q = '0;
    return {q, v};
  endfunction

  assign op_i = resolve(reg_qi, rob_qi_rdy, rob_vi, reg_vi);
  assign op_j = resolve(reg_qj, rob_qj_rdy, rob_vj, reg_vj);

  always_ff @(posedge clk) begin
    if (push) begin
      pc_m[tail]  <= in_pc;
      imm_m[tail] <= in_imm;
      opt_m[tail] <= in_optype;
      rd_m[tail]  <= in_rd;
      rs1_m[tail] <= in_rs1;
      rs2_m[tail] <= in_rs2;
      ls_m[tail]  <= in_is_ls;
      jmp_m[tail] <= in_is_jump;
      pj_m[tail]  <= in_pred_jump;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rollback) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (go)   head <= head + AW'(1);
      unique case (1'b1)
        push && !go: count <= count + CW'(1);
        go && !push: count <= count - CW'(1);
        default:     count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rob_en        <= 1'b0;
      rs_en         <= 1'b0;
      lsb_en        <= 1'b0;
      rename_en     <= 1'b0;
      rename_rd     <= '0;
      rename_alias  <= '0;
      rob_pc        <= '0;
      rob_rd        <= '0;
      rob_is_jump   <= 1'b0;
      rob_pred_jump <= 1'b0;
      rob_optype    <= '0;
      iss_alias     <= '0;
      iss_optype    <= '0;
      iss_pc        <= '0;
      iss_imm       <= '0;
      iss_vi        <= '0;
      iss_vj        <= '0;
      iss_qi        <= '0;
      iss_qj        <= '0;
    end else begin
      rob_en    <= go;
      rs_en     <= go && !head_ls;
      lsb_en    <= go && head_ls;
      rename_en <= go && (rd_m[head] != 5'd0);
      if (go) begin
        rename_rd     <= rd_m[head];
        rename_alias  <= rob_next_id;
        rob_pc        <= pc_m[head];
        rob_rd        <= rd_m[head];
        rob_is_jump   <= jmp_m[head];
        rob_pred_jump <= pj_m[head];
        rob_optype    <= opt_m[head];
        iss_alias     <= rob_next_id;
        iss_optype    <= opt_m[head];
        iss_pc        <= pc_m[head];
        iss_imm       <= imm_m[head];
        {iss_qi, iss_vi} <= op_i;
        {iss_qj, iss_vj} <= op_j;
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [31:0] issued_q, stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (go) issued_q <= issued_q + 32'd1;
      if (rdy && !empty && !go && !rollback) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`else
  assign stat_issued = 32'd0;
  assign stat_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized bench for dispatch_queue against a queue-based reference model.
// Directed cases cover issue, CDB bypass, backpressure, rd=0, rollback and stats.
module tb_dispatch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy, rollback, in_valid, in_ready;
  logic [31:0] in_pc, in_imm;
  logic [5:0]  in_optype;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic        in_is_ls, in_is_jump, in_pred_jump;
  logic        rob_full, rs_full, lsb_full;
  logic [3:0]  rob_next_id;
  logic [4:0]  rs1_2reg, rs2_2reg;
  logic [3:0]  reg_qi, reg_qj, rob_qi, rob_qj;
  logic [31:0] reg_vi, reg_vj, rob_vi, rob_vj;
  logic        rob_qi_rdy, rob_qj_rdy;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_alias;
  logic [63:0] cdb_value;
  logic        rename_en, rob_en, rob_is_jump, rob_pred_jump, rs_en, lsb_en;
  logic [4:0]  rename_rd, rob_rd;
  logic [3:0]  rename_alias, iss_alias, iss_qi, iss_qj;
  logic [31:0] rob_pc, iss_pc, iss_imm, iss_vi, iss_vj;
  logic [5:0]  rob_optype, iss_optype;
  logic [31:0] stat_issued, stat_stall;

  dispatch_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_optype(in_optype),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_is_ls(in_is_ls), .in_is_jump(in_is_jump),
    .in_pred_jump(in_pred_jump),
    .rob_full(rob_full), .rob_next_id(rob_next_id),
    .rs_full(rs_full), .lsb_full(lsb_full),
    .rs1_2reg(rs1_2reg), .rs2_2reg(rs2_2reg),
    .reg_qi(reg_qi), .reg_qj(reg_qj), .reg_vi(reg_vi), .reg_vj(reg_vj),
    .rob_qi(rob_qi), .rob_qj(rob_qj),
    .rob_qi_rdy(rob_qi_rdy), .rob_qj_rdy(rob_qj_rdy),
    .rob_vi(rob_vi), .rob_vj(rob_vj),
    .cdb_valid(cdb_valid), .cdb_alias(cdb_alias), .cdb_value(cdb_value),
    .rename_en(rename_en), .rename_rd(rename_rd),
    .rename_alias(rename_alias),
    .rob_en(rob_en), .rob_pc(rob_pc), .rob_rd(rob_rd),
    .rob_is_jump(rob_is_jump), .rob_pred_jump(rob_pred_jump),
    .rob_optype(rob_optype),
    .rs_en(rs_en), .lsb_en(lsb_en),
    .iss_alias(iss_alias), .iss_optype(iss_optype),
    .iss_pc(iss_pc), .iss_imm(iss_imm),
    .iss_vi(iss_vi), .iss_vj(iss_vj), .iss_qi(iss_qi), .iss_qj(iss_qj),
    .stat_issued(stat_issued), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, imm;
    logic [5:0]  opt;
    logic [4:0]  rd, rs1, rs2;
    logic        ls, jmp, pj;
  } ent_t;

  ent_t q[$];

  logic [3:0]  e_en;
  logic [4:0]  e_ren_rd;
  logic [3:0]  e_ren_al;
  logic [31:0] e_pc, e_imm;
  logic [4:0]  e_rd;
  logic        e_jmp, e_pj;
  logic [5:0]  e_opt;
  logic [3:0]  e_alias;
  logic [35:0] e_opi, e_opj;
  logic [31:0] e_iss, e_stall;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  function automatic logic [35:0] resolve(input logic [3:0] tag,
    input logic rr, input logic [31:0] robv, input logic [31:0] regv);
    if (tag == 4'd0) return {4'd0, regv};
    if (rr) return {4'd0, robv};
    for (int k = 0; k < 2; k++)
      if (cdb_valid[k] && cdb_alias[k*4 +: 4] == tag)
        return {4'd0, cdb_value[k*32 +: 32]};
    return {tag, 32'd0};
  endfunction

  task automatic clear_model();
    q.delete();
    e_en = '0; e_ren_rd = '0; e_ren_al = '0; e_pc = '0; e_imm = '0;
    e_rd = '0; e_jmp = 0; e_pj = 0; e_opt = '0; e_alias = '0;
    e_opi = '0; e_opj = '0; e_iss = '0; e_stall = '0;
  endtask

  task automatic idle();
    rdy = 1; rollback = 0; in_valid = 0;
    in_pc = '0; in_imm = '0; in_optype = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_is_ls = 0; in_is_jump = 0; in_pred_jump = 0;
    rob_full = 0; rs_full = 0; lsb_full = 0; rob_next_id = '0;
    reg_qi = '0; reg_qj = '0; reg_vi = '0; reg_vj = '0;
    rob_qi_rdy = 0; rob_qj_rdy = 0; rob_vi = '0; rob_vj = '0;
    cdb_valid = '0; cdb_alias = '0; cdb_value = '0;
  endtask

  task automatic check_outs(input string pfx);
    check({pfx, "_en"}, {rob_en, rs_en, lsb_en, rename_en}, e_en);
    check({pfx, "_rob"}, {rob_pc, rob_rd, rob_is_jump, rob_pred_jump, rob_optype},
          {e_pc, e_rd, e_jmp, e_pj, e_opt});
    check({pfx, "_ren"}, {rename_rd, rename_alias}, {e_ren_rd, e_ren_al});
    check({pfx, "_iss"}, {iss_alias, iss_optype, iss_pc, iss_imm},
          {e_alias, e_opt, e_pc, e_imm});
    check({pfx, "_ops"}, {iss_qi, iss_vi, iss_qj, iss_vj}, {e_opi, e_opj});
`ifdef DISPATCH_STATS_EN
    check({pfx, "_stat"}, {stat_issued, stat_stall}, {e_iss, e_stall});
`else
    check({pfx, "_stat"}, {stat_issued, stat_stall}, 64'd0);
`endif
  endtask

  task automatic step();
    logic go, push, stall;
    ent_t h, n;
    #1;
    check("in_ready", in_ready, rdy && q.size() < DEPTH && !rollback);
    check("rob_q", {rob_qi, rob_qj}, {reg_qi, reg_qj});
    if (q.size() > 0) check("srcs", {rs1_2reg, rs2_2reg}, {q[0].rs1, q[0].rs2});
    @(posedge clk);
    push = in_valid && rdy && !rollback && q.size() < DEPTH;
    go = 0;
    if (rdy && !rollback && q.size() > 0 && !rob_full)
      go = q[0].ls ? !lsb_full : !rs_full;
    stall = rdy && q.size() > 0 && !go && !rollback;
    e_iss += go ? 1 : 0;
    e_stall += stall ? 1 : 0;
    e_en = '0;
    if (go) begin
      h = q.pop_front();
      e_en = {1'b1, !h.ls, h.ls, h.rd != 5'd0};
      e_ren_rd = h.rd; e_ren_al = rob_next_id; e_alias = rob_next_id;
      e_pc = h.pc; e_imm = h.imm; e_rd = h.rd; e_opt = h.opt;
      e_jmp = h.jmp; e_pj = h.pj;
      e_opi = resolve(reg_qi, rob_qi_rdy, rob_vi, reg_vi);
      e_opj = resolve(reg_qj, rob_qj_rdy, rob_vj, reg_vj);
    end
    if (push) begin
      n.pc = in_pc; n.imm = in_imm; n.opt = in_optype; n.rd = in_rd;
      n.rs1 = in_rs1; n.rs2 = in_rs2; n.ls = in_is_ls;
      n.jmp = in_is_jump; n.pj = in_pred_jump;
      q.push_back(n);
    end
    if (rollback) q.delete();
    #1;
    check_outs("cyc");
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    clear_model();
    check_outs("rst");
    @(negedge clk);
    rst = 1;
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [4:0] rd,
                        input logic ls);
    in_valid = 1; in_pc = pc; in_rd = rd; in_is_ls = ls;
    in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = pc + 32'd100;
    in_optype = ls ? 6'd3 : 6'd1;
  endtask

  initial begin
    idle();
    rst = 0;
    clear_model();
    repeat (2) @(negedge clk);
    check_outs("reset");
    check("reset_ready", in_ready, 1'b1);
    rst = 1;

    set_in(32'h100, 5'd5, 0);
    reg_vi = 32'd7; rob_next_id = 4'd3;
    step();
    in_valid = 0;
    step();
    check("add_en", {rs_en, rob_en, rename_en, lsb_en}, 4'b1110);
    check("add_vals", {rename_alias, iss_vi, iss_qi}, {4'd3, 32'd7, 4'd0});

    set_in(32'h200, 5'd6, 1);
    reg_qi = 4'd4; cdb_valid = 2'b10;
    cdb_alias = 8'h40; cdb_value = {32'h55, 32'h99};
    step();
    in_valid = 0;
    step();
    check("lw_cdb", {lsb_en, rs_en, iss_qi, iss_vi}, {2'b10, 4'd0, 32'h55});
    set_in(32'h204, 5'd6, 1);
    cdb_valid = 2'b00;
    step();
    in_valid = 0;
    step();
    check("lw_nocdb", {lsb_en, iss_qi, iss_vi}, {1'b1, 4'd4, 32'd0});
    reg_qi = 0;

    lsb_full = 1;
    for (int i = 0; i < 4; i++) begin
      set_in(32'(i * 4), 5'd7, 1);
      step();
    end
    #1;
    check("full_ready", in_ready, 1'b0);
    in_valid = 0; lsb_full = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain", {lsb_en, iss_pc}, {1'b1, 32'(i * 4)});
    end

    set_in(32'h300, 5'd0, 0);
    step();
    in_valid = 0;
    step();
    check("rd0", {rob_en, rename_en}, 2'b10);

    rs_full = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(32'h400 + 32'(i), 5'd9, 0);
      step();
    end
    in_valid = 0; rollback = 1;
    step();
    rollback = 0; rs_full = 0;
    step();
    check("rb_idle", {rob_en, rs_en, lsb_en}, 3'b000);
    set_in(32'h500, 5'd10, 0);
    step();
    in_valid = 0;
    step();
    check("rb_after", {rs_en, iss_pc}, {1'b1, 32'h500});

    do_reset();
    set_in(32'h600, 5'd1, 0);
    step();
    in_valid = 0; rob_full = 1;
    repeat (3) step();
    rob_full = 0;
    for (int i = 1; i < 5; i++) begin
      set_in(32'h600 + 32'(i * 4), 5'd1, 0);
      step();
    end
    in_valid = 0;
    step();
`ifdef DISPATCH_STATS_EN
    check("stats", {stat_issued, stat_stall}, {32'd5, 32'd3});
`endif

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end
      rdy = $urandom_range(0, 9) != 0;
      rollback = $urandom_range(0, 29) == 0;
      in_valid = $urandom_range(0, 9) < 7;
      in_pc = $urandom; in_imm = $urandom; in_optype = 6'($urandom);
      in_rd = 5'($urandom_range(0, 3)); in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom); in_is_ls = 1'($urandom);
      in_is_jump = 1'($urandom); in_pred_jump = 1'($urandom);
      rob_full = $urandom_range(0, 4) == 0;
      rs_full = $urandom_range(0, 4) == 0;
      lsb_full = $urandom_range(0, 4) == 0;
      rob_next_id = 4'($urandom);
      reg_qi = 4'($urandom_range(0, 3)); reg_qj = 4'($urandom_range(0, 3));
      reg_vi = $urandom; reg_vj = $urandom;
      rob_qi_rdy = $urandom_range(0, 3) == 0;
      rob_qj_rdy = $urandom_range(0, 3) == 0;
      rob_vi = $urandom; rob_vj = $urandom;
      cdb_valid = 2'($urandom);
      cdb_alias = {4'($urandom_range(1, 3)), 4'($urandom_range(1, 3))};
      cdb_value = {$urandom, $urandom};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised issue stage sitting between the instruction fetcher/decoder and the ROB, register file, reservation station (RS) and load/store buffer (LSB). Buffers up to DEPTH decoded instructions in a FIFO, issues at most one per cycle from the head, and stalls per target unit (ROB, RS, LSB) instead of dropping work. Resolves source operands from the register file, then the ROB, then CDB_NUM broadcast channels in the issue cycle. Flushes completely on rollback.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- XLEN, 32: data/pc width.
- ROB_W, 4: ROB alias width; alias 0 means "no dependency / value ready".
- OPT_W, 6: optype width.
- CDB_NUM, 2: number of result broadcast channels; at least 1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global pause; low freezes the FIFO and blocks accept/issue.
- rollback  in  1  misprediction flush.
- in_valid, in_ready  in/out  1  fetch handshake; transfer when both high; in_ready = rdy && count<DEPTH && !rollback (combinational).
- in_pc, in_imm  in  XLEN  instruction pc, decoded immediate.
- in_optype  in  OPT_W; in_rd, in_rs1, in_rs2  in  5; in_is_ls, in_is_jump, in_pred_jump  in  1.
- rob_full  in  1; rob_next_id  in  ROB_W  alias for the instruction issued this cycle.
- rs_full, lsb_full  in  1  target backpressure.
- rs1_2reg, rs2_2reg  out  5  head's sources (combinational).
- reg_qi, reg_qj  in  ROB_W; reg_vi, reg_vj  in  XLEN  register file rename tag/value.
- rob_qi, rob_qj  out  ROB_W  equal reg_qi/reg_qj; rob_qi_rdy, rob_qj_rdy  in  1; rob_vi, rob_vj  in  XLEN.
- cdb_valid  in  CDB_NUM; cdb_alias  in  CDB_NUM*ROB_W; cdb_value  in  CDB_NUM*XLEN  (channel k at slice k).
- rename_en  out  1; rename_rd  out  5; rename_alias  out  ROB_W.
- rob_en  out  1; rob_pc  out  XLEN; rob_rd  out  5; rob_is_jump, rob_pred_jump  out  1; rob_optype  out  OPT_W.
- rs_en, lsb_en  out  1  one-hot or both low.
- iss_alias  out  ROB_W; iss_optype  out  OPT_W; iss_pc, iss_imm, iss_vi, iss_vj  out  XLEN; iss_qi, iss_qj  out  ROB_W  shared bus qualified by rs_en/lsb_en.
- stat_issued, stat_stall  out  32  counters (see Configuration).

## Operation
- FIFO: head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus count of log2(DEPTH)+1 bits. Push on in_valid&&in_ready.
- Issue condition `go`: rdy && !rollback && count>0 && !rob_full && (head.is_ls ? !lsb_full : !rs_full). On go: pop head; push and pop in the same cycle leave count unchanged.
- Operand resolution for each source S, in priority order:
  - If reg tag is 0: Q=0, V=reg value.
  - Else if ROB reports ready: Q=0, V=ROB value.
  - Else Q=reg tag, V=0.
  - Then, if Q≠0 and any cdb_valid[k] with cdb_alias[k]==Q: Q=0, V=cdb_value[k]. The lowest k wins.
- On go, the registered outputs load:
  - rob_en=1 with the head's fields.
  - rename_en=(rd≠0), rename_rd=rd, rename_alias=rob_next_id.
  - iss_* fields; iss_alias=rob_next_id.
  - lsb_en=is_ls, rs_en=!is_ls.
- On any other non-reset cycle, all enables are 0 and the data outputs hold.

## Timing
- Reset (rst low, asynchronous): count, head, tail, all enables and all data outputs are 0; statistics are 0.
- Latency: an instruction accepted at edge N becomes head at N, and its outputs are valid after edge N+1, when the FIFO was empty and no stall occurs.
- Throughput: one instruction per cycle sustained when DEPTH≥2.
- Stall: head is held with its fields unchanged; enables are 0 for every stalled cycle; no duplicate issue.
- rollback high at an edge: FIFO emptied, pointers 0, enables 0. Rollback overrides push, pop and rdy.
- rdy low: no push, no pop, enables 0 at the next edge.
- FIFO full: in_ready is low even if a pop occurs that cycle; there is no full-bypass.
- Reset asserted mid-stream: takes effect immediately and discards all contents.

## Configuration
- DISPATCH_STATS_EN defined:
  - stat_issued increments on each go.
  - stat_stall increments on each cycle with rdy && count>0 && !go && !rollback.
  - Both counters wrap at 2^32 and clear on reset only.
- DISPATCH_STATS_EN undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Reset, then push add (rd=5, rs1=1 with reg_qi=0, reg_vi=7), rob_next_id=3 -> two edges later: rs_en=1, rob_en=1, rename_en=1, rename_alias=3, iss_vi=7, iss_qi=0.
- Head lw with reg_qi=4, rob_qi_rdy=0, cdb_valid=2'b10, cdb_alias[1]=4, cdb_value[1]=0x55 -> lsb_en=1, iss_qi=0, iss_vi=0x55. Repeat with no CDB match -> iss_qi=4, iss_vi=0.
- DEPTH=4, lsb_full=1, push 4 loads -> in_ready=0 after 4 accepts, no enables. Release lsb_full -> 4 consecutive lsb_en pulses, in fifo order (pc 0,4,8,12).
- Push instruction with rd=0 -> rob_en=1, rename_en=0.
- FIFO holding 3 entries, rollback pulse -> next cycle count=0, all enables 0; a new push issues normally with head pointer wrapped correctly.
- DISPATCH_STATS_EN defined: 5 issues plus 3 rob_full stall cycles -> stat_issued=5, stat_stall=3.
